// File: rtl/soc_mmio.sv
// MMIO bridge: I/O page decode, LED register, UART TX with FIFO, read-data mux.
// Optional UART receiver compiled in with SOC_MMIO_UART_RX_EN.
module soc_mmio #(
    parameter int CLK_HZ       = 25000000,
    parameter int BAUD         = 115200,
    parameter int LED_W        = 8,
    parameter int TXFIFO_DEPTH = 4,
    parameter int IO_BIT       = 22
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_wmask,
    input  logic             mem_rstrb,
    output logic [31:0]      mem_rdata,
    input  logic [31:0]      ram_rdata,
    output logic [3:0]       ram_wmask,
    output logic             ram_rstrb,
    output logic [LED_W-1:0] led,
    output logic             uart_txd,
    input  logic             uart_rxd
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam int AW  = $clog2(TXFIFO_DEPTH);
    localparam logic [CW-1:0] DIV_END = CW'(DIV - 1);

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    logic       is_io, io_wr, push, pop, accept;
    logic [1:0] idx;
    assign is_io     = mem_addr[IO_BIT];
    assign idx       = mem_addr[3:2];
    assign io_wr     = is_io && (mem_wmask != 4'b0000);
    assign ram_wmask = is_io ? 4'b0000 : mem_wmask;
    assign ram_rstrb = is_io ? 1'b0 : mem_rstrb;

    logic unused_bits;
    assign unused_bits = ^{mem_addr, mem_wdata, uart_rxd};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) led <= '0;
        else if (io_wr && idx == 2'd0) led <= mem_wdata[LED_W-1:0];
    end

    // TX FIFO: pointers carry an extra wrap bit so count = wptr - rptr
    logic [7:0]  fifo_mem [TXFIFO_DEPTH];
    logic [AW:0] wptr, rptr, fifo_cnt;
    logic        fifo_empty, fifo_full;
    logic [7:0]  fifo_head;
    assign fifo_cnt   = wptr - rptr;
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == (AW+1)'(TXFIFO_DEPTH));
    assign fifo_head  = fifo_mem[rptr[AW-1:0]];
    assign push       = io_wr && idx == 2'd1;
    assign accept     = push && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (accept) fifo_mem[wptr[AW-1:0]] <= mem_wdata[7:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (accept) wptr <= wptr + 1'b1;
            if (pop)    rptr <= rptr + 1'b1;
        end
    end

    logic [1:0]    tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_sh;
    logic          tx_end, tx_idle;
    assign tx_end  = (tx_cnt == DIV_END);
    assign pop     = !fifo_empty && (tx_state == TX_IDLE || (tx_state == TX_STOP && tx_end));
    assign tx_idle = fifo_empty && tx_state == TX_IDLE;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
        end else begin
            tx_cnt <= (tx_state == TX_IDLE || tx_end) ? '0 : tx_cnt + 1'b1;
            case (tx_state)
                TX_IDLE: if (pop) begin
                    tx_state <= TX_START;
                    tx_sh    <= fifo_head;
                end
                TX_START: if (tx_end) begin
                    tx_state <= TX_DATA;
                    tx_bit   <= '0;
                end
                TX_DATA: if (tx_end) begin
                    tx_sh  <= {1'b0, tx_sh[7:1]};
                    tx_bit <= tx_bit + 1'b1;
                    if (tx_bit == 3'd7) tx_state <= TX_STOP;
                end
                default: if (tx_end) begin
                    if (pop) begin
                        tx_state <= TX_START;
                        tx_sh    <= fifo_head;
                    end else begin
                        tx_state <= TX_IDLE;
                    end
                end
            endcase
        end
    end

    // Derived from reset-cleared state, so the line goes high asynchronously on reset
    always_comb begin
        case (tx_state)
            TX_START: uart_txd = 1'b0;
            TX_DATA:  uart_txd = tx_sh[0];
            default:  uart_txd = 1'b1;
        endcase
    end

    logic tx_overflow, w1c_ovf;
    assign w1c_ovf = io_wr && idx == 2'd2 && mem_wdata[2];
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) tx_overflow <= 1'b0;
        else tx_overflow <= (push && fifo_full && !pop) || (tx_overflow && !w1c_ovf);
    end

    logic       rx_valid, rx_overrun, rx_frame_err;
    logic [7:0] rx_data;
`ifdef SOC_MMIO_UART_RX_EN
    logic          rx_s1, rx_s2, rx_s3, rx_busy, rx_at, rx_done, rx_bad, data_rd;
    logic [CW-1:0] rx_cnt;
    logic [3:0]    rx_bitn;
    logic [7:0]    rx_sh;
    assign data_rd = is_io && mem_rstrb && idx == 2'd1;
    assign rx_at   = rx_busy && rx_cnt == ((rx_bitn == 4'd0) ? CW'(DIV/2 - 1) : DIV_END);
    assign rx_done = rx_at && rx_bitn == 4'd9 && rx_s2;
    assign rx_bad  = rx_at && rx_bitn == 4'd9 && !rx_s2;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            {rx_s1, rx_s2, rx_s3} <= 3'b111;
            rx_busy <= 1'b0;
            rx_cnt  <= '0;
            rx_bitn <= '0;
            rx_sh   <= '0;
            rx_data <= '0;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_s1 <= uart_rxd;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
            if (!rx_busy) begin
                if (rx_s3 && !rx_s2) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= '0;
                    rx_bitn <= '0;
                end
            end else if (rx_at) begin
                rx_cnt  <= '0;
                rx_bitn <= rx_bitn + 1'b1;
                if (rx_bitn == 4'd9) rx_busy <= 1'b0;
                else if (rx_bitn != 4'd0) rx_sh <= {rx_s2, rx_sh[7:1]};
            end else begin
                rx_cnt <= rx_cnt + 1'b1;
            end
            if (rx_done) rx_data <= rx_sh;
            rx_valid     <= rx_done || (rx_valid && !data_rd);
            rx_overrun   <= (rx_done && rx_valid && !data_rd) ||
                            (rx_overrun && !(io_wr && idx == 2'd2 && mem_wdata[4]));
            rx_frame_err <= rx_bad || (rx_frame_err && !(io_wr && idx == 2'd2 && mem_wdata[5]));
        end
    end
`else
    assign rx_valid     = 1'b0;
    assign rx_overrun   = 1'b0;
    assign rx_frame_err = 1'b0;
    assign rx_data      = '0;
`endif

    logic [31:0] io_sel, io_rdata_q;
    logic        is_io_q;
    always_comb begin
        io_sel = '0;
        case (idx)
            2'd0: io_sel[LED_W-1:0] = led;
            2'd1: io_sel[7:0] = rx_data;
            2'd2: io_sel[5:0] = {rx_frame_err, rx_overrun, rx_valid, tx_overflow, tx_idle, fifo_full};
            default: io_sel = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            is_io_q    <= 1'b0;
            io_rdata_q <= '0;
        end else if (mem_rstrb) begin
            is_io_q <= is_io;
            if (is_io) io_rdata_q <= io_sel;
        end
    end

    assign mem_rdata = is_io_q ? io_rdata_q : ram_rdata;
endmodule

// File: tb/tb_soc_mmio.sv
// Directed self-checking bench for soc_mmio (DIV=16, 4-entry TX FIFO).
module tb_soc_mmio;
    logic        clk, resetn;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, ram_rdata;
    logic [3:0]  mem_wmask, ram_wmask;
    logic        mem_rstrb, ram_rstrb;
    logic [7:0]  led;
    logic        uart_txd, uart_rxd, rx_loop;
    int          n_cmp, n_err;

    soc_mmio #(.CLK_HZ(16), .BAUD(1), .LED_W(8), .TXFIFO_DEPTH(4), .IO_BIT(22)) dut (
        .clk(clk), .resetn(resetn), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
        .ram_rdata(ram_rdata), .ram_wmask(ram_wmask), .ram_rstrb(ram_rstrb),
        .led(led), .uart_txd(uart_txd), .uart_rxd(uart_rxd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    assign uart_rxd = rx_loop ? uart_txd : 1'b1;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        mem_addr  = a;
        mem_wdata = d;
        mem_wmask = 4'b0001;
        tick();
        mem_wmask = 4'b0000;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        mem_addr  = a;
        mem_rstrb = 1'b1;
        tick();
        mem_rstrb = 1'b0;
        d = mem_rdata;
    endtask

    task automatic wait_fall(input int budget, output bit found);
        int n = 0;
        while (uart_txd !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        found = (uart_txd === 1'b0);
    endtask

    task automatic get_frame(output logic [7:0] b);
        bit found;
        b = 8'h00;
        wait_fall(400, found);
        check("frame_start_seen", {31'b0, found}, 32'd1);
        if (found) begin
            repeat (8) tick();
            for (int i = 0; i < 8; i++) begin
                repeat (16) tick();
                b[i] = uart_txd;
            end
            repeat (16) tick();
            check("frame_stop", {31'b0, uart_txd}, 32'd1);
        end
    endtask

    logic [31:0] d;
    logic [7:0]  b;
    bit          found;

    initial begin
        n_cmp = 0; n_err = 0;
        resetn = 1'b0; rx_loop = 1'b0;
        mem_addr = '0; mem_wdata = '0; mem_wmask = '0; mem_rstrb = 1'b0;
        ram_rdata = 32'hDEADBEEF;
        repeat (3) tick();
        check("reset_led", {24'b0, led}, 32'h0);
        check("reset_txd", {31'b0, uart_txd}, 32'd1);
        check("reset_rdata_ram", mem_rdata, 32'hDEADBEEF);
        resetn = 1'b1;
        tick();
        rd(32'h400008, d);
        check("reset_status", d, 32'h2);

        // LED write and readback
        mem_addr = 32'h400000; mem_wdata = 32'h000000A5; mem_wmask = 4'b0001;
        #1 check("led_ram_wmask", {28'b0, ram_wmask}, 32'h0);
        tick();
        mem_wmask = 4'b0000;
        check("led_value", {24'b0, led}, 32'hA5);
        mem_rstrb = 1'b1;
        #1 check("io_ram_rstrb", {31'b0, ram_rstrb}, 32'd0);
        tick();
        mem_rstrb = 1'b0;
        check("led_read", mem_rdata, 32'hA5);
        rd(32'h40000C, d);
        check("reg_c_read", d, 32'h0);
        rd(32'h400004, d);
        check("uart_data_read_norx", d, 32'h0);

        // Single TX frame, bit boundaries checked at both ends of every bit
        wr(32'h400004, 32'h55);
        check("tx_not_yet", {31'b0, uart_txd}, 32'd1);
        tick();
        for (int k = 0; k < 10; k++) begin
            logic [9:0] fr;
            fr = {1'b1, 8'h55, 1'b0};
            check($sformatf("tx_bit%0d_first", k), {31'b0, uart_txd}, {31'b0, fr[k]});
            repeat (15) tick();
            check($sformatf("tx_bit%0d_last", k), {31'b0, uart_txd}, {31'b0, fr[k]});
            tick();
        end
        rd(32'h400008, d);
        check("tx_idle_after", d, 32'h2);

        // Overflow: six back-to-back pushes, five frames out
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    get_frame(b);
                    check($sformatf("ovf_frame%0d", i), {24'b0, b}, 32'h11 + i);
                end
                wait_fall(200, found);
                check("ovf_no_sixth", {31'b0, found}, 32'd0);
            end
            begin
                for (int i = 0; i < 6; i++) wr(32'h400004, 32'h11 + i);
                rd(32'h400008, d);
                check("ovf_status", d, 32'h5);
                wr(32'h400008, 32'h4);
                rd(32'h400008, d);
                check("ovf_cleared", d, 32'h1);
            end
        join

        // RAM passthrough
        mem_addr = 32'h10; mem_wdata = 32'hFFFFFFFF; mem_wmask = 4'b0110;
        #1 check("ram_wmask", {28'b0, ram_wmask}, 32'h6);
        tick();
        mem_wmask = 4'b0000;
        check("ram_store_led_kept", {24'b0, led}, 32'hA5);
        ram_rdata = 32'h12345678;
        mem_rstrb = 1'b1;
        #1 check("ram_rstrb", {31'b0, ram_rstrb}, 32'd1);
        tick();
        mem_rstrb = 1'b0;
        check("ram_read", mem_rdata, 32'h12345678);
        rd(32'h400000, d);
        check("led_after_ram", d, 32'hA5);

`ifdef SOC_MMIO_UART_RX_EN
        rx_loop = 1'b1;
        wr(32'h400004, 32'h3C);
        repeat (180) tick();
        rd(32'h400008, d);
        check("rx_valid", d, 32'hA);
        rd(32'h400004, d);
        check("rx_byte", d, 32'h3C);
        wr(32'h400004, 32'h3C);
        repeat (180) tick();
        wr(32'h400004, 32'hC3);
        repeat (180) tick();
        rd(32'h400008, d);
        check("rx_overrun", d, 32'h1A);
        rd(32'h400004, d);
        check("rx_overwritten", d, 32'hC3);
        rx_loop = 1'b0;
`endif

        // Reset mid-frame discards the frame and queued bytes
        wr(32'h400004, 32'hA3);
        wr(32'h400004, 32'h5A);
        repeat (50) tick();
        check("mid_frame_low", {31'b0, uart_txd}, 32'd0);
        resetn = 1'b0;
        #1 check("reset_async_txd", {31'b0, uart_txd}, 32'd1);
        tick();
        check("reset_led_clr", {24'b0, led}, 32'h0);
        #3 resetn = 1'b1;
        tick();
        rd(32'h400008, d);
        check("post_reset_status", d, 32'h2);
        wait_fall(200, found);
        check("post_reset_no_frame", {31'b0, found}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
